// File: rtl/hex_count_source.sv
// Run/pause 8-bit counter feeding the two-digit hex display decoders.
// Define BCD_MODE_EN for two-digit decimal counting (00..99) instead of binary 0..MAX.
module hex_count_source #(
    parameter int PRESCALE = 50000000,
    parameter int MAX      = 255
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [7:0] LoadVal,
    input  logic       Dir,
    input  logic       Run_btn,
    input  logic       Step_btn,
    output logic [7:0] Digits,
    output logic       Running,
    output logic       Wrap
);

    localparam int             PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]     MAX_V   = 8'(MAX);

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_nxt;
    logic [PW-1:0] presc_q;
    logic          run_p0, run_p1, run_p2, run_arm;
    logic          step_p0, step_p1, step_p2, step_arm;
    logic          live_p0, live_p1;
    logic          run_pulse, step_pulse, tick, do_step;
    logic [8:0]    next_val;

    // Returns {wrap, value} for one count step in the given direction.
    function automatic logic [8:0] count_step(input logic [7:0] v, input logic up);
`ifdef BCD_MODE_EN
        if (up) begin
            if (v[3:0] >= 4'd9) begin
                if (v[7:4] >= 4'd9) return {1'b1, 8'h00};
                else                return {1'b0, v[7:4] + 4'd1, 4'd0};
            end
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v[3:0] == 4'd0) begin
                if (v[7:4] == 4'd0) return {1'b1, 8'h99};
                else                return {1'b0, v[7:4] - 4'd1, 4'd9};
            end
            return {1'b0, v[7:4], v[3:0] - 4'd1};
        end
`else
        if (up) begin
            if (v == MAX_V) return {1'b1, 8'h00};
            return {1'b0, v + 8'd1};
        end else begin
            if (v == 8'h00) return {1'b1, MAX_V};
            return {1'b0, v - 8'd1};
        end
`endif
    endfunction

    function automatic logic [7:0] clamp_load(input logic [7:0] v);
`ifdef BCD_MODE_EN
        return {(v[7:4] > 4'd9) ? 4'd9 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
`else
        return (v > MAX_V) ? MAX_V : v;
`endif
    endfunction

    // Button synchronizers; a press only counts once a real released level has
    // been sampled, so buttons held through reset release are ignored.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            run_p0   <= 1'b1;
            run_p1   <= 1'b1;
            run_p2   <= 1'b1;
            step_p0  <= 1'b1;
            step_p1  <= 1'b1;
            step_p2  <= 1'b1;
            live_p0  <= 1'b0;
            live_p1  <= 1'b0;
            run_arm  <= 1'b0;
            step_arm <= 1'b0;
        end else begin
            run_p0   <= Run_btn;
            run_p1   <= run_p0;
            run_p2   <= run_p1;
            step_p0  <= Step_btn;
            step_p1  <= step_p0;
            step_p2  <= step_p1;
            live_p0  <= 1'b1;
            live_p1  <= live_p0;
            run_arm  <= run_arm  | (live_p1 & run_p1);
            step_arm <= step_arm | (live_p1 & step_p1);
        end
    end

    assign run_pulse  = run_arm  & run_p2  & ~run_p1;
    assign step_pulse = step_arm & step_p2 & ~step_p1;

    always_comb begin
        state_nxt = state_q;
        tick      = 1'b0;
        do_step   = 1'b0;
        if (run_pulse)
            state_nxt = (state_q == RUN) ? PAUSE : RUN;
        if (state_q == RUN)
            tick = (presc_q == PS_LAST);
        do_step  = tick | (step_pulse & (state_q == PAUSE));
        next_val = count_step(Digits, Dir);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= PAUSE;
            Running <= 1'b0;
        end else begin
            state_q <= state_nxt;
            Running <= (state_nxt == RUN);
        end
    end

    // Prescaler only runs while the counter stays in RUN; entry to RUN starts at 0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            presc_q <= '0;
        else if (Load || state_q != RUN || state_nxt != RUN || tick)
            presc_q <= '0;
        else
            presc_q <= presc_q + PW'(1);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Digits <= 8'h00;
            Wrap   <= 1'b0;
        end else if (Load) begin
            Digits <= clamp_load(LoadVal);
            Wrap   <= 1'b0;
        end else if (do_step) begin
            Digits <= next_val[7:0];
            Wrap   <= next_val[8];
        end else begin
            Wrap   <= 1'b0;
        end
    end

endmodule

// File: doc/hex_count_source.md
Name: hex_count_source

Overview:
- Upstream stage for the two-digit seven-segment decoder pair.
- Produces the 8-bit value whose nibbles drive the low and high hex digits.
- Value is a run/pause counter with the following controls:
  - prescaled auto-increment;
  - pushbutton start/stop and single-step;
  - parallel load from switches;
  - up/down direction.
- Outputs are registered; the decoder stage stays purely combinational.

Parameters:
- PRESCALE, 50000000, clock cycles per count step in RUN (legal range 2..2^26).
- MAX, 255, terminal count for wrap (0..255). Ignored when BCD_MODE_EN is defined.

Ports:
- Clock  input  1  system clock, all logic rising-edge.
- Resetn  input  1  asynchronous active-low reset.
- Load  input  1  level; while high, count takes LoadVal.
- LoadVal  input  8  parallel load value (switch bank).
- Dir  input  1  1 = count up, 0 = count down.
- Run_btn  input  1  raw active-low pushbutton; each press toggles RUN/PAUSE.
- Step_btn  input  1  raw active-low pushbutton; single step in PAUSE.
- Digits  output  8  current count; [3:0] low digit, [7:4] high digit.
- Running  output  1  high in RUN state.
- Wrap  output  1  one-cycle pulse on terminal-count wrap.

Behaviour:
- Reset (Resetn low, asynchronous, immediate): Digits=0, Running=0, Wrap=0, prescaler=0, state=PAUSE. Button synchronizer flops go to 1 (released).
- Button inputs:
  - Each button passes through a 2-flop synchronizer, then a 3rd flop for edge detection.
  - A press is a 1->0 transition of the synchronized signal and gives a one-cycle pulse.
  - No debounce; the bench drives clean levels.
  - Count/state reacts on the 3rd rising edge after the raw input falls.
- State machine, 2 states:
  - PAUSE: run pulse -> RUN.
  - RUN: run pulse -> PAUSE.
  - Running = (state==RUN), registered.
- Prescaler:
  - Advances only in RUN; count range 0..PRESCALE-1.
  - tick asserts in the cycle it equals PRESCALE-1; it then wraps to 0.
  - Cleared to 0 on entry to PAUSE and while Load is high.
  - First tick after entering RUN occurs PRESCALE cycles later.
- Count step, taken on a tick in RUN or a step pulse in PAUSE:
  - Up: Count==MAX -> 0 with Wrap=1; else Count+1.
  - Down: Count==0 -> MAX with Wrap=1; else Count-1.
  - Wrap is asserted in the same cycle Digits takes the wrapped value, for one cycle only.
- Load:
  - Load high: Count <= (LoadVal > MAX ? MAX : LoadVal).
  - Overrides any tick or step in the same cycle; no Wrap.
  - State unchanged.
- Simultaneous events:
  - Run pulse and tick in the same cycle: the step is applied, then the state toggles.
  - Step pulse in RUN: ignored.
  - Dir change mid-RUN: takes effect at the next tick; prescaler is not reset.
- Reset mid-RUN: returns to PAUSE with Digits=0. Buttons held at reset release produce no spurious press.

Optional Feature:
- Macro BCD_MODE_EN.
- Defined:
  - Each nibble counts 0..9 with decimal carry/borrow between nibbles.
  - Wrap occurs at 99->00 (up) and 00->99 (down); MAX is ignored.
  - Any LoadVal nibble above 9 is clamped to 9 on load.
- Undefined: plain binary counting, MAX wrap and clamp as above.

Test Plan:
- Reset: assert Resetn=0 while RUN with Digits=8'h37 -> Digits=8'h00, Running=0 without waiting for a clock edge. Releasing reset with both buttons held low -> no state change.
- PRESCALE=4, MAX=255, Dir=1, press Run_btn -> Running=1 after 3 cycles. Digits then reads 01, 02, 03 at 4-cycle intervals.
- Load LoadVal=8'hFE, run up -> FE, FF, 00. Wrap=1 for exactly the one cycle Digits becomes 00.
- PAUSE, Digits=00, Dir=0, MAX=8'hC7, press Step_btn -> Digits=C7, Wrap pulse. Press Step_btn in RUN -> no extra step.
- Load high in the tick cycle with LoadVal=8'h3C -> Digits=3C, not 3D. Next step lands 4 cycles after Load falls. LoadVal=8'hF0 with MAX=8'hC7 -> Digits=C7.
- BCD_MODE_EN: load 8'h98, run up -> 99, then 00 with Wrap. Load 8'h09, run up -> 10. Load 8'hAF -> 99.
